// File: rtl/rr_timeout_arbiter_pkg.sv
// Shared definitions for the round-robin timeout arbiter: FSM encodings and
// index helpers sized for the largest supported requester count.
package rr_timeout_arbiter_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Circular successor of idx in a ring of n entries.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W:0]   n);
    logic [IDX_W:0] inc;
    inc = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
    if (inc >= n) begin
      next_idx = {IDX_W{1'b0}};
    end else begin
      next_idx = inc[IDX_W-1:0];
    end
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = {MAX_REQ{1'b0}};
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_timeout_arbiter_pick.sv
// Combinational circular priority search: first set request bit at or after
// ptr, wrapping at N_REQ.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             found
);

  // Scan offsets 0..N_REQ-1 from ptr; the first hit wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = {ID_W{1'b0}};
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end else begin
        found  = found;
      end
    end
  end

endmodule

// File: rtl/rr_timeout_arbiter.sv
// Round-robin arbiter with bounded hold: grants one requester at a time,
// rotates priority after each grant and preempts owners past MAX_HOLD.
module rr_timeout_arbiter
  import rr_timeout_arbiter_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             preempt,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  // With MAX_HOLD = 0 the counter only saturates at its full range.
  localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  arb_state_t       state_r, state_s;
  logic [ID_W-1:0]  ptr_r, ptr_s;
  logic [ID_W-1:0]  owner_r, owner_s;
  logic [ID_W-1:0]  winner_s;
  logic             found_s;
  logic [N_REQ-1:0] owner_oh_s;
  logic [N_REQ-1:0] others_s;
  logic [N_REQ-1:0] grant_s;
  logic             grant_valid_s;
  logic [ID_W-1:0]  grant_id_s;
  logic             preempt_s;
  logic [CNT_W-1:0] hold_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .winner (winner_s),
    .found  (found_s)
  );

  assign owner_oh_s = N_REQ'(onehot(IDX_W'(owner_r)));
  assign others_s   = req & ~owner_oh_s;

  // Next-state and next-output logic; every release returns to an idle gap.
  always_comb begin
    state_s       = state_r;
    ptr_s         = ptr_r;
    owner_s       = owner_r;
    grant_s       = grant;
    grant_valid_s = grant_valid;
    grant_id_s    = grant_id;
    preempt_s     = 1'b0;
    hold_s        = hold_cnt;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s       = ST_GRANT;
          owner_s       = winner_s;
          grant_s       = N_REQ'(onehot(IDX_W'(winner_s)));
          grant_valid_s = 1'b1;
          grant_id_s    = winner_s;
          hold_s        = {{(CNT_W-1){1'b0}}, 1'b1};
          ptr_s         = ID_W'(next_idx(IDX_W'(winner_s), (IDX_W+1)'(N_REQ)));
        end else begin
          grant_s       = {N_REQ{1'b0}};
          grant_valid_s = 1'b0;
          grant_id_s    = {ID_W{1'b0}};
          hold_s        = {CNT_W{1'b0}};
        end
      end
      ST_GRANT: begin
        if (!req[owner_r] ||
            ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && (others_s != {N_REQ{1'b0}}))) begin
          state_s       = ST_IDLE;
          preempt_s     = req[owner_r];
          grant_s       = {N_REQ{1'b0}};
          grant_valid_s = 1'b0;
          grant_id_s    = {ID_W{1'b0}};
          hold_s        = {CNT_W{1'b0}};
        end else if (hold_cnt < HOLD_SAT) begin
          hold_s = hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          hold_s = hold_cnt;
        end
      end
      default: begin
        state_s       = ST_IDLE;
        grant_s       = {N_REQ{1'b0}};
        grant_valid_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        hold_s        = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {ID_W{1'b0}};
      owner_r     <= {ID_W{1'b0}};
      grant       <= {N_REQ{1'b0}};
      grant_valid <= 1'b0;
      grant_id    <= {ID_W{1'b0}};
      preempt     <= 1'b0;
      hold_cnt    <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      owner_r     <= owner_s;
      grant       <= grant_s;
      grant_valid <= grant_valid_s;
      grant_id    <= grant_id_s;
      preempt     <= preempt_s;
      hold_cnt    <= hold_s;
    end
  end

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD 4 and 0) share stimulus; a
// behavioural model queues expected outputs that are compared after each edge.
module tb_rr_timeout_arbiter;

  typedef struct {
    logic       st;
    int         ptr;
    int         owner;
    logic [2:0] grant;
    logic [1:0] gid;
    logic       pre;
    int         hold;
  } mstate_t;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] g4, g0;
  logic       gv4, gv0;
  logic [1:0] id4, id0;
  logic       p4, p0;
  logic [3:0] h4, h0;

  int checks;
  int failures;

  mstate_t m4, m0;
  mstate_t q4[$];
  mstate_t q0[$];

  rr_timeout_arbiter #(.N_REQ(3), .ID_W(2), .MAX_HOLD(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .grant(g4), .grant_valid(gv4),
    .grant_id(id4), .preempt(p4), .hold_cnt(h4)
  );

  rr_timeout_arbiter #(.N_REQ(3), .ID_W(2), .MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .grant(g0), .grant_valid(gv0),
    .grant_id(id0), .preempt(p0), .hold_cnt(h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t z;
    z.st = 1'b0; z.ptr = 0; z.owner = 0; z.grant = 3'b000;
    z.gid = 2'd0; z.pre = 1'b0; z.hold = 0;
    return z;
  endfunction

  // Reference behaviour of one clock edge.
  function automatic mstate_t model(mstate_t m, logic [2:0] r, int lim);
    mstate_t n;
    int w;
    int sat;
    n     = m;
    n.pre = 1'b0;
    sat   = (lim == 0) ? 15 : lim;
    if (!m.st) begin
      w = -1;
      for (int k = 0; k < 3; k++) begin
        if (w < 0 && r[(m.ptr + k) % 3]) w = (m.ptr + k) % 3;
      end
      if (w >= 0) begin
        n.st = 1'b1; n.owner = w; n.grant = 3'b001 << w; n.gid = 2'(w);
        n.hold = 1; n.ptr = (w + 1) % 3;
      end else begin
        n.grant = 3'b000; n.gid = 2'd0; n.hold = 0;
      end
    end else if (!r[m.owner]) begin
      n.st = 1'b0; n.grant = 3'b000; n.gid = 2'd0; n.hold = 0;
    end else if (lim != 0 && m.hold == lim && (r & ~(3'b001 << m.owner)) != 3'b000) begin
      n.st = 1'b0; n.grant = 3'b000; n.gid = 2'd0; n.hold = 0; n.pre = 1'b1;
    end else begin
      n.hold = (m.hold + 1 > sat) ? sat : m.hold + 1;
    end
    return n;
  endfunction

  task automatic cmp(input string nm, input logic [2:0] g, input logic gv, input logic [1:0] id,
                     input logic p, input logic [3:0] h, input mstate_t e);
    check({nm, ".grant"}, 32'(g), 32'(e.grant));
    check({nm, ".grant_valid"}, 32'(gv), 32'(e.grant != 3'b000));
    check({nm, ".grant_id"}, 32'(id), 32'(e.gid));
    check({nm, ".preempt"}, 32'(p), 32'(e.pre));
    check({nm, ".hold_cnt"}, 32'(h), 32'(e.hold));
    check({nm, ".inv_valid"}, 32'(gv), 32'(|g));
    check({nm, ".inv_pre_gv"}, 32'(p & gv), 32'd0);
  endtask

  task automatic step(input logic [2:0] r);
    mstate_t e;
    @(negedge clk);
    req = r;
    m4 = model(m4, r, 4);
    q4.push_back(m4);
    m0 = model(m0, r, 0);
    q0.push_back(m0);
    @(posedge clk);
    #1;
    if (q4.size() == 0) begin
      check("q4_empty", 32'd1, 32'd0);
    end else begin
      e = q4.pop_front();
      cmp("mh4", g4, gv4, id4, p4, h4, e);
    end
    if (q0.size() == 0) begin
      check("q0_empty", 32'd1, 32'd0);
    end else begin
      e = q0.pop_front();
      cmp("mh0", g0, gv0, id0, p0, h0, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    m4 = mreset();
    m0 = mreset();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 3'b000;
    m4       = mreset();
    m0       = mreset();
    repeat (2) @(negedge clk);
    check("rst.grant", 32'(g4), 32'd0);
    check("rst.grant_valid", 32'(gv4), 32'd0);
    check("rst.grant_id", 32'(id4), 32'd0);
    check("rst.preempt", 32'(p4), 32'd0);
    check("rst.hold_cnt", 32'(h4), 32'd0);
    rst = 1'b0;

    // Asynchronous reset in the middle of a grant to requester 1.
    step(3'b010);
    step(3'b010);
    check("pre_arst.grant", 32'(g4), 32'h2);
    #2;
    rst = 1'b1;
    req = 3'b000;
    #1;
    check("arst.grant", 32'(g4), 32'd0);
    check("arst.grant_valid", 32'(gv4), 32'd0);
    check("arst.hold_cnt", 32'(h4), 32'd0);
    check("arst.grant0", 32'(g0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m4  = mreset();
    m0  = mreset();
    step(3'b110);
    check("arst_restart.grant", 32'(g4), 32'h2);
    step(3'b110);
    step(3'b000);
    step(3'b000);

    // Lone requester holds past MAX_HOLD without preemption.
    do_reset();
    for (int i = 0; i < 10; i++) step(3'b001);
    check("lone.hold_sat", 32'(h4), 32'd4);

    // All requesting: rotation with preemption.
    do_reset();
    for (int i = 0; i < 18; i++) step(3'b111);

    // Owner drops early, then wrap-around from requester 2 back to 0.
    do_reset();
    step(3'b101);
    for (int i = 0; i < 3; i++) step(3'b100);
    check("drop.grant_id", 32'(id4), 32'd2);
    step(3'b000);
    step(3'b101);
    check("wrap.grant", 32'(g4), 32'h1);
    step(3'b101);

    // Unlimited hold on the MAX_HOLD = 0 instance.
    do_reset();
    for (int i = 0; i < 20; i++) step(3'b011);
    check("unlim.hold_sat", 32'(h0), 32'd15);
    check("unlim.grant", 32'(g0), 32'h1);

    // Random request traffic.
    do_reset();
    for (int i = 0; i < 40; i++) step(3'($urandom_range(0, 7)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
